// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared fixed-point types and helpers for the motor-control datapath
//
// Purpose : Q1.15 sample type, its saturation helper, and the elaboration-time
//           sine generator used to fill the quarter-wave lookup tables.
// Contents: q15_t, Q15_ONE, Q15_MIN, sat_q15(), sin_q15_entry()
package motor_pkg;

  typedef logic signed [15:0] q15_t;

  localparam q15_t Q15_ONE = 16'sd32767;
  localparam q15_t Q15_MIN = 16'sh8000;

  // pi scaled by 2**60, taken from the hexadecimal expansion of pi
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  function automatic q15_t sat_q15(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return Q15_ONE;
    end else if (v < -64'sd32768) begin
      return Q15_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

  // sin(pi/2 * idx/quarter) in Q1.15, rounded to nearest, top clamped to 32767.
  // Evaluated only at elaboration; a Taylor series in 2**-60 fixed point keeps
  // the error far below the rounding step.
  function automatic q15_t sin_q15_entry(input int idx, input int quarter);
    logic [127:0] x;
    logic [127:0] term;
    logic [127:0] acc;
    logic [127:0] val;
    x    = (PI_Q60 * 128'(idx)) / 128'(2 * quarter);
    term = x;
    acc  = x;
    for (int k = 1; k <= 12; k++) begin
      term = (term * x) >> 60;
      term = (term * x) >> 60;
      term = term / 128'((2 * k) * (2 * k + 1));
      if ((k % 2) == 1) begin
        acc = acc - term;
      end else begin
        acc = acc + term;
      end
    end
    val = ((acc << 15) + (128'd1 << 59)) >> 60;
    if (val > 128'd32767) begin
      val = 128'd32767;
    end
    return q15_t'(val[15:0]);
  endfunction

endpackage

// File: rtl/park_sincos_lut.sv
// rtl/park_sincos_lut.sv - quarter-wave sine/cosine lookup with registered Q1.15 outputs
//
// Purpose : Maps an unsigned angle code to sin/cos in Q1.15 with one cycle of
//           latency. Outputs hold while en_i is low.
// Ports   : clk, reset (sync, active-low), en_i (advance), theta_i (angle code),
//           sin_o / cos_o (registered, signed Q1.15)
module park_sincos_lut
  import motor_pkg::*;
#(
  parameter int THETA_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic [THETA_WIDTH-1:0] theta_i,
  output q15_t                   sin_o,
  output q15_t                   cos_o
);

  localparam int QW      = THETA_WIDTH - 2;
  localparam int QUARTER = 1 << QW;
  localparam logic [QW:0]            QTR       = (QW + 1)'(QUARTER);
  localparam logic [THETA_WIDTH-1:0] THETA_QTR = THETA_WIDTH'(QUARTER);

  // quarter-wave table, entries 0 .. QUARTER inclusive
  q15_t rom [QUARTER + 1];
  for (genvar gi = 0; gi <= QUARTER; gi++) begin : g_rom
    localparam q15_t ENTRY = sin_q15_entry(gi, QUARTER);
    assign rom[gi] = ENTRY;
  end

  logic [THETA_WIDTH-1:0] theta_cos;
  logic [QW:0]            sin_idx;
  logic [QW:0]            cos_idx;
  q15_t                   sin_d;
  q15_t                   cos_d;
  q15_t                   sin_q;
  q15_t                   cos_q;

  // cos(t) = sin(t + quarter turn)
  assign theta_cos = theta_i + THETA_QTR;

  // quadrant bit 0 mirrors the index, quadrant bit 1 negates after lookup
  always_comb begin
    sin_idx = theta_i[QW] ? (QTR - {1'b0, theta_i[QW-1:0]}) : {1'b0, theta_i[QW-1:0]};
    cos_idx = theta_cos[QW] ? (QTR - {1'b0, theta_cos[QW-1:0]}) : {1'b0, theta_cos[QW-1:0]};
    sin_d   = theta_i[QW+1]   ? -rom[sin_idx] : rom[sin_idx];
    cos_d   = theta_cos[QW+1] ? -rom[cos_idx] : rom[cos_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sin_q <= '0;
      cos_q <= '0;
    end else if (en_i) begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

  assign sin_o = sin_q;
  assign cos_o = cos_q;

endmodule

// File: rtl/park_transform.sv
// rtl/park_transform.sv - alpha/beta to d/q rotation, 4-stage stallable pipeline
//
// Purpose : d = a*cos(t) + b*sin(t), q = -a*sin(t) + b*cos(t), rounded half up
//           and saturated. Stages: S0 input regs, S1 sin/cos lookup, S2 products,
//           S3 sum/round/saturate into the output register.
// Ports   : clk, reset (sync, active-low)
//           in_data {beta, alpha}, in_theta, in_channel, in_valid, in_ready
//           out_data {q, d}, out_channel, out_valid, out_ready
module park_transform
  import motor_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 1,
  parameter int DATA_WIDTH    = 16,
  parameter int THETA_WIDTH   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*DATA_WIDTH-1:0]    in_data,
  input  logic [THETA_WIDTH-1:0]     in_theta,
  input  logic [CHANNEL_WIDTH-1:0]   in_channel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [2*DATA_WIDTH-1:0]    out_data,
  output logic [CHANNEL_WIDTH-1:0]   out_channel,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int PW = DATA_WIDTH + 16;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] ROUND_HALF = SW'(16384);
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [DATA_WIDTH-1:0] sat_dw(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      return v[DATA_WIDTH-1:0];
    end
  endfunction

  logic advance;

  logic                           s0_valid_q;
  logic signed [DATA_WIDTH-1:0]   s0_a_q;
  logic signed [DATA_WIDTH-1:0]   s0_b_q;
  logic [THETA_WIDTH-1:0]         s0_theta_q;
  logic [CHANNEL_WIDTH-1:0]       s0_ch_q;

  logic                           s1_valid_q;
  logic signed [DATA_WIDTH-1:0]   s1_a_q;
  logic signed [DATA_WIDTH-1:0]   s1_b_q;
  logic [CHANNEL_WIDTH-1:0]       s1_ch_q;
  q15_t                           s1_sin;
  q15_t                           s1_cos;

  logic                           s2_valid_q;
  logic [CHANNEL_WIDTH-1:0]       s2_ch_q;
  logic signed [PW-1:0]           s2_ac_q;
  logic signed [PW-1:0]           s2_bs_q;
  logic signed [PW-1:0]           s2_as_q;
  logic signed [PW-1:0]           s2_bc_q;

  logic signed [SW-1:0]           d_sum;
  logic signed [SW-1:0]           q_sum;
  logic signed [SW-1:0]           d_rnd;
  logic signed [SW-1:0]           q_rnd;
  logic [2*DATA_WIDTH-1:0]        out_data_d;

  logic                           out_valid_q;
  logic [2*DATA_WIDTH-1:0]        out_data_q;
  logic [CHANNEL_WIDTH-1:0]       out_ch_q;

  // the whole pipe moves together; a stalled output freezes every stage
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  park_sincos_lut #(
    .THETA_WIDTH (THETA_WIDTH)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .en_i    (advance),
    .theta_i (s0_theta_q),
    .sin_o   (s1_sin),
    .cos_o   (s1_cos)
  );

  always_comb begin
    d_sum      = SW'(s2_ac_q) + SW'(s2_bs_q);
    q_sum      = SW'(s2_bc_q) - SW'(s2_as_q);
    d_rnd      = (d_sum + ROUND_HALF) >>> 15;
    q_rnd      = (q_sum + ROUND_HALF) >>> 15;
    out_data_d = {sat_dw(q_rnd), sat_dw(d_rnd)};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s0_valid_q  <= 1'b0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s0_theta_q  <= '0;
      s0_ch_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ch_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_ch_q     <= '0;
      s2_ac_q     <= '0;
      s2_bs_q     <= '0;
      s2_as_q     <= '0;
      s2_bc_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (advance) begin
      s0_valid_q  <= in_valid;
      s0_a_q      <= in_data[DATA_WIDTH-1:0];
      s0_b_q      <= in_data[2*DATA_WIDTH-1:DATA_WIDTH];
      s0_theta_q  <= in_theta;
      s0_ch_q     <= in_channel;

      s1_valid_q  <= s0_valid_q;
      s1_a_q      <= s0_a_q;
      s1_b_q      <= s0_b_q;
      s1_ch_q     <= s0_ch_q;

      s2_valid_q  <= s1_valid_q;
      s2_ch_q     <= s1_ch_q;
      s2_ac_q     <= PW'(s1_a_q) * PW'(s1_cos);
      s2_bs_q     <= PW'(s1_b_q) * PW'(s1_sin);
      s2_as_q     <= PW'(s1_a_q) * PW'(s1_sin);
      s2_bc_q     <= PW'(s1_b_q) * PW'(s1_cos);

      out_valid_q <= s2_valid_q;
      out_data_q  <= out_data_d;
      out_ch_q    <= s2_ch_q;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_ch_q;

endmodule

// File: tb/tb_park_transform.sv
// tb/tb_park_transform.sv - directed and scoreboard checks for park_transform
module tb_park_transform;

  localparam real PI = 3.14159265358979;
  localparam int K_EXACT = 0;
  localparam int K_REAL  = 1;
  localparam int K_SWEEP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [9:0]  in_theta;
  logic [0:0]  in_channel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [0:0]  out_channel;
  logic        out_valid;
  logic        out_ready;

  park_transform dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_theta    (in_theta),
    .in_channel  (in_channel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    shortint    a;
    shortint    b;
    logic [9:0] th;
    logic       ch;
    int         kind;
    int         ed;
    int         eq;
  } beat_t;

  beat_t src_q[$];
  beat_t exp_q[$];
  beat_t vec[9];

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  int          first_valid_cyc = -1;
  int          valid_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [0:0]  prev_ch = '0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  function automatic beat_t mk(input int a, input int b, input int th, input int ch,
                               input int kind, input int ed, input int eq);
    beat_t r;
    r.a = shortint'(a); r.b = shortint'(b); r.th = 10'(th); r.ch = ch[0];
    r.kind = kind; r.ed = ed; r.eq = eq;
    return r;
  endfunction

  task automatic compare_out(input beat_t e);
    int  d, q;
    real t, dr, qr;
    d = $signed(out_data[15:0]);
    q = $signed(out_data[31:16]);
    check("channel", out_channel[0] == e.ch, out_channel, e.ch);
    if (e.kind == K_EXACT) begin
      check("d_exact", d == e.ed, d, e.ed);
      check("q_exact", q == e.eq, q, e.eq);
    end else if (e.kind == K_REAL) begin
      t  = 2.0 * PI * real'(e.th) / 1024.0;
      dr = real'(e.a) * $cos(t) + real'(e.b) * $sin(t);
      qr = -real'(e.a) * $sin(t) + real'(e.b) * $cos(t);
      if (dr > 32767.0) dr = 32767.0;
      if (dr < -32768.0) dr = -32768.0;
      if (qr > 32767.0) qr = 32767.0;
      if (qr < -32768.0) qr = -32768.0;
      check("d_model", (real'(d) - dr) <= 1.0 && (dr - real'(d)) <= 1.0, d, $rtoi(dr));
      check("q_model", (real'(q) - qr) <= 1.0 && (qr - real'(q)) <= 1.0, q, $rtoi(qr));
    end else begin
      check("sweep_d", d >= 32766 && d <= 32767, d, 32766);
      check("sweep_q", q >= -2 && q <= 2, q, 0);
    end
  endtask

  // one clock: drive at negedge, sample 1 time unit later, well before posedge
  task automatic cycle(input logic rdy);
    beat_t e;
    @(negedge clk);
    out_ready = rdy;
    if (src_q.size() > 0) begin
      in_valid   = 1'b1;
      in_data    = {src_q[0].b, src_q[0].a};
      in_theta   = src_q[0].th;
      in_channel = src_q[0].ch;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    cyc++;
    if (prev_stall) begin
      check("stall_hold", out_valid && out_data == prev_data && out_channel == prev_ch,
            out_data, prev_data);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_ch    = out_channel;
    if (out_valid) begin
      valid_seen++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b0, out_data, 0);
      end else begin
        e = exp_q.pop_front();
        compare_out(e);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(src_q.pop_front());
      last_acc_cyc = cyc;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle(1'b1);
      n++;
    end
    check({name, "_drain"}, src_q.size() == 0 && exp_q.size() == 0,
          src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int   n, hold;
    logic rdy;
    real  t;

    vec[0] = mk(1000, 500, 0, 0, K_EXACT, 1000, 500);
    vec[1] = mk(1000, 500, 256, 1, K_EXACT, 500, -1000);
    vec[2] = mk(1000, 500, 512, 0, K_EXACT, -1000, -500);
    vec[3] = mk(32767, 32767, 128, 1, K_EXACT, 32767, 0);
    vec[4] = mk(1000, 500, 768, 0, K_EXACT, -500, 1000);
    vec[5] = mk(-32768, -32768, 128, 1, K_EXACT, -32768, 0);
    vec[6] = mk(10000, 0, 64, 0, K_EXACT, 9239, -3827);
    vec[7] = mk(1000, 0, 1023, 1, K_EXACT, 1000, 6);
    vec[8] = mk(0, -1000, 256, 0, K_EXACT, -1000, 0);

    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_theta   = '0;
    in_channel = '0;
    out_ready  = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_out_data", out_data == 32'd0, out_data, 0);
    check("rst_out_channel", out_channel == 1'b0, out_channel, 0);
    check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    reset = 1'b1;

    // latency of a single beat
    first_valid_cyc = -1;
    src_q.push_back(vec[0]);
    drain("latency", 30);
    check("latency", first_valid_cyc - last_acc_cyc == 4, first_valid_cyc - last_acc_cyc, 4);

    // directed table, back to back
    for (int i = 0; i < 9; i++) src_q.push_back(vec[i]);
    drain("table", 60);

    // full stall: only four beats fit, in_ready drops once out_valid rises
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(mk(int'($urandom_range(0, 16000)) - 8000,
                         int'($urandom_range(0, 16000)) - 8000,
                         int'($urandom_range(0, 1023)), i % 2, K_REAL, 0, 0));
    end
    repeat (20) cycle(1'b0);
    check("stall_in_ready", in_ready == 1'b0, in_ready, 0);
    check("stall_held_beats", exp_q.size() == 4, exp_q.size(), 4);
    drain("stall_release", 60);

    // random backpressure
    for (int i = 0; i < 64; i++) begin
      src_q.push_back(mk(int'($urandom_range(0, 16000)) - 8000,
                         int'($urandom_range(0, 16000)) - 8000,
                         int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)),
                         K_REAL, 0, 0));
    end
    n = 0;
    hold = 0;
    rdy = 1'b1;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < 4000) begin
      if (hold == 0) begin
        rdy  = ~rdy;
        hold = int'($urandom_range(0, 10));
      end else begin
        hold--;
      end
      cycle(rdy);
      n++;
    end
    check("backpressure_drain", src_q.size() == 0 && exp_q.size() == 0,
          src_q.size() + exp_q.size(), 0);

    // full-circle rotation of a unit vector
    for (int th = 0; th < 1024; th++) begin
      t = 2.0 * PI * real'(th) / 1024.0;
      src_q.push_back(mk($rtoi($floor(32767.0 * $cos(t) + 0.5)),
                         $rtoi($floor(32767.0 * $sin(t) + 0.5)),
                         th, th % 2, K_SWEEP, 0, 0));
    end
    drain("sweep", 1200);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) src_q.push_back(vec[i + 1]);
    repeat (3) cycle(1'b1);
    check("mid_in_flight", exp_q.size() == 3, exp_q.size(), 3);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("mid_rst_out_data", out_data == 32'd0, out_data, 0);
    check("mid_rst_in_ready", in_ready == 1'b1, in_ready, 1);
    reset = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    valid_seen = 0;
    repeat (12) cycle(1'b1);
    check("no_stale_beat", valid_seen == 0, valid_seen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
